// File: rtl/audio_pkg.sv
// Shared audio clocking definitions: rate codes, clock generator states, half-period table.
// Latency: none, declarations and a pure function only.
// Backpressure: not applicable.
package audio_pkg;

  localparam int BCLK_PER_FRAME = 64;
  localparam int BIT_CNT_W      = $clog2(BCLK_PER_FRAME);
  localparam int HALF_CNT_W     = 4;

  // rate_sel encoding; the reserved code runs at 48 kHz
  typedef enum logic [1:0] {
    RATE_48K  = 2'b00,
    RATE_32K  = 2'b01,
    RATE_8K   = 2'b10,
    RATE_RSVD = 2'b11
  } rate_e;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'b00,
    ST_SETTLE    = 2'b01,
    ST_RUN       = 2'b10
  } state_e;

  // BCLK half-period in 12.288 MHz cycles for a given rate
  function automatic logic [HALF_CNT_W-1:0] half_period(input rate_e rate);
    logic [HALF_CNT_W-1:0] h;
    case (rate)
      RATE_32K: h = HALF_CNT_W'(3);
      RATE_8K:  h = HALF_CNT_W'(12);
      default:  h = HALF_CNT_W'(2);
    endcase
    return h;
  endfunction

endpackage

// File: rtl/audio_sync2.sv
// Two-flop synchronizer for a single asynchronous level into clk.
// Latency: 2 clk cycles from input change to q.
// Backpressure: none; free-running.
module audio_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // shift the raw level through two stages
  always_comb begin
    sync_d = {sync_q[0], d};
  end

  // synchronizer stages, cleared to "unlocked" by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/audio_i2s_clkgen.sv
// I2S BCLK/LRCLK generator with lock qualification; optional frame counter via AUDIO_CLKGEN_FRAME_CNT_EN.
// Latency: running rises SETTLE_CYCLES+3 cycles after pll_locked rises; all outputs registered.
// Backpressure: none; strobes are single-cycle and cannot be stalled by consumers.
module audio_i2s_clkgen
  import audio_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pll_locked,
  input  logic [1:0]  rate_sel,
  output logic        running,
  output logic        bclk,
  output logic        lrclk,
  output logic        bclk_rise,
  output logic        bclk_fall,
  output logic        frame_start
`ifdef AUDIO_CLKGEN_FRAME_CNT_EN
  ,
  output logic [31:0] frame_cnt
`endif
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  logic                  lock_s;

  state_e                state_q, state_d;
  logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
  rate_e                 rate_q, rate_d;
  logic [HALF_CNT_W-1:0] half_cnt_q, half_cnt_d;
  logic [HALF_CNT_W-1:0] half_last;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  bclk_q, bclk_d;
  logic                  lrclk_q, lrclk_d;
  logic                  bclk_rise_q, bclk_rise_d;
  logic                  bclk_fall_q, bclk_fall_d;
  logic                  frame_start_q, frame_start_d;
`ifdef AUDIO_CLKGEN_FRAME_CNT_EN
  logic [31:0]           frame_cnt_q, frame_cnt_d;
`endif

  logic                  run_active;
  logic                  run_entry;

  audio_sync2 u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  // lock qualification: wait for lock, hold it for SETTLE_CYCLES, then run until lock drops
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        settle_cnt_d = '0;
        if (lock_s) begin
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!lock_s) begin
          state_d      = ST_WAIT_LOCK;
          settle_cnt_d = '0;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          state_d      = ST_RUN;
          settle_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        settle_cnt_d = '0;
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end
      end
      default: begin
        state_d      = ST_WAIT_LOCK;
        settle_cnt_d = '0;
      end
    endcase
  end

  // Counters only advance when both this cycle and the next are RUN: the entry
  // cycle starts from cleared state, and a lock loss clears outputs on the same
  // edge that drops running.
  assign run_active = (state_q == ST_RUN) && (state_d == ST_RUN);
  assign run_entry  = (state_q == ST_SETTLE) && (state_d == ST_RUN);
  assign half_last  = half_period(rate_q) - HALF_CNT_W'(1);

  // BCLK/LRCLK waveform and strobes; rate only changes at frame boundaries
  always_comb begin
    half_cnt_d    = '0;
    bit_cnt_d     = '0;
    bclk_d        = 1'b0;
    lrclk_d       = 1'b0;
    bclk_rise_d   = 1'b0;
    bclk_fall_d   = 1'b0;
    frame_start_d = 1'b0;
    rate_d        = rate_q;
`ifdef AUDIO_CLKGEN_FRAME_CNT_EN
    frame_cnt_d   = '0;
`endif
    if (run_entry) begin
      rate_d = rate_e'(rate_sel);
    end
    if (run_active) begin
      half_cnt_d = half_cnt_q + 1'b1;
      bit_cnt_d  = bit_cnt_q;
      bclk_d     = bclk_q;
      lrclk_d    = lrclk_q;
`ifdef AUDIO_CLKGEN_FRAME_CNT_EN
      frame_cnt_d = frame_cnt_q;
`endif
      if (half_cnt_q == half_last) begin
        half_cnt_d = '0;
        bclk_d     = ~bclk_q;
        if (bclk_q) begin
          bclk_fall_d = 1'b1;
          bit_cnt_d   = bit_cnt_q + 1'b1;
          lrclk_d     = bit_cnt_d[BIT_CNT_W-1];
          if (bit_cnt_d == '0) begin
            frame_start_d = 1'b1;
            // the next half-period already runs at the newly selected rate
            rate_d        = rate_e'(rate_sel);
`ifdef AUDIO_CLKGEN_FRAME_CNT_EN
            frame_cnt_d   = frame_cnt_q + 32'd1;
`endif
          end
        end else begin
          bclk_rise_d = 1'b1;
        end
      end
    end
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_WAIT_LOCK;
      settle_cnt_q  <= '0;
      rate_q        <= RATE_48K;
      half_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      bclk_q        <= 1'b0;
      lrclk_q       <= 1'b0;
      bclk_rise_q   <= 1'b0;
      bclk_fall_q   <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef AUDIO_CLKGEN_FRAME_CNT_EN
      frame_cnt_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      rate_q        <= rate_d;
      half_cnt_q    <= half_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      bclk_q        <= bclk_d;
      lrclk_q       <= lrclk_d;
      bclk_rise_q   <= bclk_rise_d;
      bclk_fall_q   <= bclk_fall_d;
      frame_start_q <= frame_start_d;
`ifdef AUDIO_CLKGEN_FRAME_CNT_EN
      frame_cnt_q   <= frame_cnt_d;
`endif
    end
  end

  assign running     = (state_q == ST_RUN);
  assign bclk        = bclk_q;
  assign lrclk       = lrclk_q;
  assign bclk_rise   = bclk_rise_q;
  assign bclk_fall   = bclk_fall_q;
  assign frame_start = frame_start_q;
`ifdef AUDIO_CLKGEN_FRAME_CNT_EN
  assign frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_audio_i2s_clkgen.sv
// Self-checking bench for audio_i2s_clkgen: per-rate vector table, corner sequences, random rate changes.
// Latency: n/a.
// Backpressure: n/a.
module tb_audio_i2s_clkgen;

  localparam int S = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic [1:0] rate_sel = 2'b00;
  logic       running, bclk, lrclk, bclk_rise, bclk_fall, frame_start;
`ifdef AUDIO_CLKGEN_FRAME_CNT_EN
  logic [31:0] frame_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  audio_i2s_clkgen #(.SETTLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .rate_sel    (rate_sel),
    .running     (running),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .bclk_rise   (bclk_rise),
    .bclk_fall   (bclk_fall),
    .frame_start (frame_start)
`ifdef AUDIO_CLKGEN_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] rate;
    int         exp_h;
    int         exp_frame;
  } vec_t;

  vec_t tbl [4];

  // reference model state: time since RUN entry, current frame start and half-period
  int         m_t, m_base, m_h, m_frames, fs_t0, fs_t1, first_rise, lr_bad, n_fs;
  bit         m_first;
  logic [1:0] m_prev_rate;
  logic       m_prev_lr;

  function automatic int hp(input logic [1:0] r);
    case (r)
      2'b01:   return 3;
      2'b10:   return 12;
      default: return 2;
    endcase
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] r);
    rst = 1'b1;
    pll_locked = 1'b0;
    rate_sel = r;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_running(output int n, input int limit);
    n = 0;
    while (!running && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic model_init();
    m_t = 0;
    m_base = 0;
    m_h = hp(rate_sel);
    m_first = 1'b1;
    m_frames = 0;
    fs_t0 = -1;
    fs_t1 = -1;
    first_rise = -1;
    lr_bad = 0;
    n_fs = 0;
    m_prev_rate = rate_sel;
    m_prev_lr = lrclk;
  endtask

  // A frame is 128 half-periods at one H; the next frame's H comes from the
  // rate_sel value present at the edge that starts it.
  task automatic run_cycles(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      int rel;
      int per;
      logic [5:0] exp_v;
      logic [5:0] act_v;
      rel = m_t - m_base;
      if (rel == 128 * m_h) begin
        m_base = m_t;
        rel = 0;
        m_h = hp(m_prev_rate);
        m_first = 1'b0;
        m_frames++;
      end
      per = 2 * m_h;
      exp_v = {1'b1,
               ((rel / m_h) % 2) == 1,
               (rel / per) >= 32,
               (rel % per) == m_h,
               ((rel % per) == 0) && !(m_first && rel == 0),
               (rel == 0) && !m_first};
      act_v = {running, bclk, lrclk, bclk_rise, bclk_fall, frame_start};
      chk($sformatf("model t=%0d {run,bclk,lr,rise,fall,fs}", m_t), longint'(act_v), longint'(exp_v));
`ifdef AUDIO_CLKGEN_FRAME_CNT_EN
      chk($sformatf("frame_cnt t=%0d", m_t), longint'(frame_cnt), longint'(m_frames));
`endif
      if (frame_start) begin
        n_fs++;
        if (fs_t0 < 0) fs_t0 = m_t;
        else if (fs_t1 < 0) fs_t1 = m_t;
      end
      if (bclk && first_rise < 0) first_rise = m_t;
      if (lrclk !== m_prev_lr && !bclk_fall) lr_bad++;
      m_prev_lr = lrclk;
      if (rnd && $urandom_range(0, 149) == 0) rate_sel = 2'($urandom_range(0, 3));
      m_prev_rate = rate_sel;
      tick();
      m_t++;
    end
  endtask

  initial begin
    int n;
    int early;
    int quiet;

    tbl[0] = '{2'b00, 2, 256};
    tbl[1] = '{2'b01, 3, 384};
    tbl[2] = '{2'b10, 12, 1536};
    tbl[3] = '{2'b11, 2, 256};

    // reset state
    tick();
    chk("reset_outputs", longint'({running, bclk, lrclk, bclk_rise, bclk_fall, frame_start}), 0);
`ifdef AUDIO_CLKGEN_FRAME_CNT_EN
    chk("reset_frame_cnt", longint'(frame_cnt), 0);
`endif

    // per-rate table: lock latency, first rise, full waveform, frame length
    for (int k = 0; k < 4; k++) begin
      do_reset(tbl[k].rate);
      repeat (5) tick();
      pll_locked = 1'b1;
      wait_running(n, 200);
      chk($sformatf("run_lat[%0d]", k), n, S + 3);
      model_init();
      run_cycles(2 * tbl[k].exp_frame + 8, 1'b0);
      chk($sformatf("first_rise[%0d]", k), first_rise, tbl[k].exp_h);
      chk($sformatf("first_fs[%0d]", k), fs_t0, tbl[k].exp_frame);
      chk($sformatf("frame_len[%0d]", k), fs_t1 - fs_t0, tbl[k].exp_frame);
      chk($sformatf("lr_without_fall[%0d]", k), lr_bad, 0);
    end

    // rate change 48k -> 8k mid-frame at bit 20
    do_reset(2'b00);
    pll_locked = 1'b1;
    wait_running(n, 200);
    chk("rchg_run_lat", n, S + 3);
    model_init();
    run_cycles(80, 1'b0);
    rate_sel = 2'b10;
    run_cycles(1720, 1'b0);
    chk("rchg_first_fs", fs_t0, 256);
    chk("rchg_frame_len", fs_t1 - fs_t0, 1536);

    // lock glitch during SETTLE restarts the full settle period
    do_reset(2'b00);
    pll_locked = 1'b1;
    early = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (running) early++;
    end
    pll_locked = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (running) early++;
    end
    pll_locked = 1'b1;
    wait_running(n, 200);
    chk("glitch_early_run", early, 0);
    chk("glitch_relock_lat", n, S + 3);

    // lock loss in RUN while lrclk is high, then relock from a clean frame
    model_init();
    run_cycles(150, 1'b0);
    chk("pre_drop_lrclk", longint'(lrclk), 1);
    pll_locked = 1'b0;
    n = 0;
    while ((running || bclk || lrclk) && n < 10) begin
      tick();
      n++;
    end
    chk("drop_within_3", longint'(n >= 1 && n <= 3), 1);
    quiet = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      quiet += int'(running | bclk | lrclk | bclk_rise | bclk_fall | frame_start);
    end
    chk("idle_quiet", quiet, 0);
    pll_locked = 1'b1;
    wait_running(n, 200);
    chk("relock_lat", n, S + 3);
    model_init();
    run_cycles(300, 1'b0);
    chk("relock_first_fs", fs_t0, 256);

    // random rate_sel changes at arbitrary times
    do_reset(2'($urandom_range(0, 3)));
    pll_locked = 1'b1;
    wait_running(n, 200);
    chk("rand_run_lat", n, S + 3);
    model_init();
    run_cycles(8000, 1'b1);
    chk("rand_lr_without_fall", lr_bad, 0);

    // asynchronous reset mid-frame after 5 frames
    do_reset(2'b00);
    pll_locked = 1'b1;
    wait_running(n, 200);
    model_init();
    run_cycles(5 * 256 + 60, 1'b0);
    chk("frames_seen", n_fs, 5);
`ifdef AUDIO_CLKGEN_FRAME_CNT_EN
    chk("frame_cnt_pre_rst", longint'(frame_cnt), 5);
`endif
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", longint'({running, bclk, lrclk, bclk_rise, bclk_fall, frame_start}), 0);
`ifdef AUDIO_CLKGEN_FRAME_CNT_EN
    chk("async_rst_frame_cnt", longint'(frame_cnt), 0);
`endif
    tick();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
